debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Multi-channel, parametrised successor to the single-key debouncer. Sits between key_encoder / raw key lines and row_scanner / spi_interface.
- Each of CHANNELS active-low inputs gets its own synchroniser, retriggerable make/break debounce FSM and counter. It produces:
  - a stretched active-low qbar,
  - a one-clk press strobe term, sampled at a programmable point,
  - a one-clk release strobe, which the single-channel version lacks.
- A priority-encoded summary, term_any and term_idx, lets one spi_interface serve all channels.

Parameters:
- CHANNELS, 4: number of independent inputs, 1..16.
- DURATION, 1000000: debounce window in clk cycles (20 ms at 50 MHz), at least 4.
- SAMPLE_POINT, 500000: count value at which a press is qualified; must be 2..DURATION-1.
- IDX_W, 2: width of term_idx; must equal clog2(CHANNELS), minimum 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- a  in  CHANNELS  raw key signals, active-low (0 = pressed), asynchronous to clk.
- qbar  out  CHANNELS  debounced/stretched key, active-low.
- term  out  CHANNELS  one-clk press-qualified strobe per channel.
- rel  out  CHANNELS  one-clk release strobe per channel.
- term_any  out  1  OR of term.
- term_idx  out  IDX_W  lowest channel index with term set; 0 when term_any=0.

Behaviour:
- Reset:
  - Asserting rst forces, immediately and asynchronously: every FSM to IDLE, counts 0, synchroniser flops 1, qbar all 1s, term/rel/term_any 0, term_idx 0, armed flags 0.
  - Reset mid-debounce discards that event; no term or rel follows it.
- Synchroniser: 2 flops per channel, reset value 1; a_s is the second flop. A stage-3 flop a_d gives edges:
  - fall = a_d & ~a_s
  - rise = ~a_d & a_s
- Counter: one counter per channel, width clog2(DURATION+1). It never exceeds DURATION and never wraps.
- FSM per channel (states IDLE, MAKE, HELD, BREAK; all outputs registered):
  - IDLE: qbar=1, count=0. On fall: go to MAKE, count<=1, qbar<=0 on the same edge. Latency from a falling to qbar falling is 3 clk.
  - MAKE:
    - fall restarts count<=1 (retrigger). Otherwise count increments.
    - When count reaches SAMPLE_POINT with a_s=0: term pulses 1 clk, armed<=1. With a_s=1 there is no term.
    - At count==DURATION: a_s=0 goes to HELD, count<=0. a_s=1 goes to IDLE and drives qbar<=1; if armed, rel pulses 1 clk and armed clears.
  - HELD: qbar=0, count=0. On rise: go to BREAK, count<=1.
  - BREAK:
    - qbar=0. Any edge (rise or fall) restarts count<=1. Otherwise count increments.
    - At count==DURATION: a_s=1 goes to IDLE with qbar<=1, rel pulses 1 clk (armed=1 by construction), armed clears. a_s=0 goes back to HELD.
  - term only ever fires in MAKE, at most once per restart. A retrigger after term has fired does not re-fire term unless count again reaches SAMPLE_POINT; armed stays 1.
- Strobe timing: term and rel are high for exactly one clk, never both in the same cycle for one channel.
- Summary outputs: term_any and term_idx are combinational from the term register, so they are valid in the same cycle as term. Simultaneous terms select the lowest index; the higher ones are still visible on term.
- Channels are fully independent; no shared counter.

Test Plan (CHANNELS=4, DURATION=16, SAMPLE_POINT=8, IDX_W=2):
- Clean press: a[0] low at cycle 0 and held 60 clk. Required: qbar[0] falls at cycle 3; term[0]=1 only at cycle 10; qbar[0] stays 0 while a[0] is low; no rel.
- Glitch: a[1] low for 2 clk, then high. Required: qbar[1] low for exactly 16 clk; term[1] and rel[1] never assert.
- Bouncy make: a[2] toggles 0/1/0/1/0 on 5 consecutive clks, then holds low. Required: count restarts at the last fall; a single term[2] 7 clk after that restart.
- Bouncy release: after case 1 reaches HELD, a[0] goes high with 3 bounces over 6 clk. Required: qbar[0] returns to 1 exactly 16 clk after the last edge; rel[0]=1 for 1 clk in that same cycle.
- Simultaneous terms: a[1] and a[3] fall on the same clk. Required: term=4'b1010 for one clk; term_any=1; term_idx=1.
- Reset mid-MAKE: rst pulsed at count=5 on ch0. Required: qbar=4'b1111 and term=0 without waiting for a clk edge. After rst drops with a[0] still low, a new fall is needed before any term.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel active-low key debouncer: per-channel synchroniser, retriggerable
// make/break FSM with press (term) and release (rel) strobes, plus a priority summary.
module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int DURATION     = 1000000,
  parameter int SAMPLE_POINT = 500000,
  parameter int IDX_W        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] qbar,
  output logic [CHANNELS-1:0] term,
  output logic [CHANNELS-1:0] rel,
  output logic                term_any,
  output logic [IDX_W-1:0]    term_idx
);

  localparam int CW = $clog2(DURATION + 1);
  localparam logic [CW-1:0] DUR_C = CW'(DURATION);
  localparam logic [CW-1:0] SP_C  = CW'(SAMPLE_POINT);
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAKE  = 2'd1,
    HELD  = 2'd2,
    BREAK = 2'd3
  } state_t;

  logic [CHANNELS-1:0] sync1_r, a_s_r, a_d_r;
  logic [CHANNELS-1:0] fall_s, rise_s;
  state_t              state_r    [CHANNELS];
  state_t              state_nx_s [CHANNELS];
  logic [CW-1:0]       count_r    [CHANNELS];
  logic [CW-1:0]       count_nx_s [CHANNELS];
  logic [CHANNELS-1:0] qbar_r, qbar_nx_s;
  logic [CHANNELS-1:0] term_r, term_nx_s;
  logic [CHANNELS-1:0] rel_r, rel_nx_s;
  logic [CHANNELS-1:0] armed_r, armed_nx_s;
  logic [IDX_W-1:0]    term_idx_s;

  // Two-flop synchroniser plus a third stage for edge detection (idles released).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '1;
      a_s_r   <= '1;
      a_d_r   <= '1;
    end else begin
      sync1_r <= a;
      a_s_r   <= sync1_r;
      a_d_r   <= a_s_r;
    end
  end

  assign fall_s = a_d_r & ~a_s_r;
  assign rise_s = ~a_d_r & a_s_r;

  // Per-channel state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= IDLE;
        count_r[i] <= '0;
      end
      qbar_r  <= '1;
      term_r  <= '0;
      rel_r   <= '0;
      armed_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= state_nx_s[i];
        count_r[i] <= count_nx_s[i];
      end
      qbar_r  <= qbar_nx_s;
      term_r  <= term_nx_s;
      rel_r   <= rel_nx_s;
      armed_r <= armed_nx_s;
    end
  end

  // Next-state logic: make window qualifies presses, break window qualifies releases.
  always_comb begin
    qbar_nx_s  = qbar_r;
    term_nx_s  = '0;
    rel_nx_s   = '0;
    armed_nx_s = armed_r;
    for (int i = 0; i < CHANNELS; i++) begin
      state_nx_s[i] = state_r[i];
      count_nx_s[i] = count_r[i];
      case (state_r[i])
        IDLE: begin
          qbar_nx_s[i]  = 1'b1;
          count_nx_s[i] = '0;
          if (fall_s[i]) begin
            state_nx_s[i] = MAKE;
            count_nx_s[i] = ONE_C;
            qbar_nx_s[i]  = 1'b0;
          end else begin
            state_nx_s[i] = IDLE;
          end
        end
        MAKE: begin
          if (fall_s[i]) begin
            count_nx_s[i] = ONE_C;
          end else if (count_r[i] == DUR_C) begin
            count_nx_s[i] = '0;
            if (!a_s_r[i]) begin
              state_nx_s[i] = HELD;
            end else begin
              // Window ended released: a qualified press still owes its release strobe.
              state_nx_s[i] = IDLE;
              qbar_nx_s[i]  = 1'b1;
              rel_nx_s[i]   = armed_r[i];
              armed_nx_s[i] = 1'b0;
            end
          end else begin
            count_nx_s[i] = count_r[i] + ONE_C;
            if (((count_r[i] + ONE_C) == SP_C) && !a_s_r[i]) begin
              term_nx_s[i]  = 1'b1;
              armed_nx_s[i] = 1'b1;
            end else begin
              term_nx_s[i] = 1'b0;
            end
          end
        end
        HELD: begin
          qbar_nx_s[i]  = 1'b0;
          count_nx_s[i] = '0;
          if (rise_s[i]) begin
            state_nx_s[i] = BREAK;
            count_nx_s[i] = ONE_C;
          end else begin
            state_nx_s[i] = HELD;
          end
        end
        BREAK: begin
          qbar_nx_s[i] = 1'b0;
          if (fall_s[i] || rise_s[i]) begin
            count_nx_s[i] = ONE_C;
          end else if (count_r[i] == DUR_C) begin
            count_nx_s[i] = '0;
            if (a_s_r[i]) begin
              state_nx_s[i] = IDLE;
              qbar_nx_s[i]  = 1'b1;
              rel_nx_s[i]   = 1'b1;
              armed_nx_s[i] = 1'b0;
            end else begin
              state_nx_s[i] = HELD;
            end
          end else begin
            count_nx_s[i] = count_r[i] + ONE_C;
          end
        end
        default: begin
          state_nx_s[i] = IDLE;
          count_nx_s[i] = '0;
          qbar_nx_s[i]  = 1'b1;
          armed_nx_s[i] = 1'b0;
        end
      endcase
    end
  end

  // Lowest-index channel wins the summary; scan high to low so low indices override.
  always_comb begin
    term_idx_s = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      term_idx_s = term_r[i] ? IDX_W'(i) : term_idx_s;
    end
  end

  assign qbar     = qbar_r;
  assign term     = term_r;
  assign rel      = rel_r;
  assign term_any = |term_r;
  assign term_idx = term_idx_s;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: a timestamp-based reference model predicts
// each cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int D  = 16;
  localparam int SP = 8;
  localparam int IW = 2;

  localparam int M_IDLE  = 0;
  localparam int M_MAKE  = 1;
  localparam int M_HELD  = 2;
  localparam int M_BREAK = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] a   = '1;
  logic [CH-1:0] qbar, term, rel;
  logic          term_any;
  logic [IW-1:0] term_idx;

  debounce_multi #(
    .CHANNELS(CH), .DURATION(D), .SAMPLE_POINT(SP), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .qbar(qbar), .term(term), .rel(rel),
    .term_any(term_any), .term_idx(term_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] qbar;
    logic [CH-1:0] term;
    logic [CH-1:0] rel;
    logic          any;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: per channel a mode, the cycle of the last window restart,
  // and the press-qualified flag. Raw input history is kept per edge.
  int            m_mode  [CH];
  int            m_t0    [CH];
  bit            m_armed [CH];
  bit            m_qbar  [CH];
  logic [CH-1:0] hist[$];
  int            rel_edge = 0;

  // Raw input value sampled at edge j; everything before reset release reads as released.
  function automatic logic [CH-1:0] ain(int j);
    if (j < rel_edge) return '1;
    return hist[j - rel_edge];
  endfunction

  task automatic model_release();
    rel_edge = cyc + 1;
    hist.delete();
    for (int c = 0; c < CH; c++) begin
      m_mode[c]  = M_IDLE;
      m_t0[c]    = 0;
      m_armed[c] = 1'b0;
      m_qbar[c]  = 1'b1;
    end
  endtask

  // Predict the outputs after the next clock edge k for the current input a.
  task automatic step();
    exp_t          e;
    int            k;
    logic [CH-1:0] sv, dv;
    bit            fall, rise;
    k = cyc + 1;
    hist.push_back(a);
    sv = ain(k - 2);
    dv = ain(k - 3);
    e.cyc  = k;
    e.term = '0;
    e.rel  = '0;
    for (int c = 0; c < CH; c++) begin
      fall = dv[c] && !sv[c];
      rise = !dv[c] && sv[c];
      case (m_mode[c])
        M_IDLE: if (fall) begin
          m_mode[c] = M_MAKE; m_t0[c] = k; m_qbar[c] = 1'b0;
        end
        M_MAKE: begin
          if (fall) m_t0[c] = k;
          else if (k == m_t0[c] + D) begin
            if (!sv[c]) m_mode[c] = M_HELD;
            else begin
              m_mode[c] = M_IDLE; m_qbar[c] = 1'b1;
              e.rel[c] = m_armed[c]; m_armed[c] = 1'b0;
            end
          end else if (k == m_t0[c] + SP - 1 && !sv[c]) begin
            e.term[c] = 1'b1; m_armed[c] = 1'b1;
          end
        end
        M_HELD: if (rise) begin
          m_mode[c] = M_BREAK; m_t0[c] = k;
        end
        M_BREAK: begin
          if (fall || rise) m_t0[c] = k;
          else if (k == m_t0[c] + D) begin
            if (sv[c]) begin
              m_mode[c] = M_IDLE; m_qbar[c] = 1'b1;
              e.rel[c] = 1'b1; m_armed[c] = 1'b0;
            end else m_mode[c] = M_HELD;
          end
        end
        default: m_mode[c] = M_IDLE;
      endcase
      e.qbar[c] = m_qbar[c];
    end
    e.any = |e.term;
    e.idx = '0;
    for (int c = 0; c < CH; c++) begin
      if (e.term[c]) begin
        e.idx = IW'(c);
        break;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare every prediction whose edge has occurred.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("qbar", qbar, e.qbar);
        check("term", term, e.term);
        check("rel", rel, e.rel);
        check("term_any", term_any, e.any);
        check("term_idx", term_idx, e.idx);
        check("term_rel_overlap", term & rel, 0);
      end
    end
  end

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      step();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_qbar", qbar, 4'hF);
    check("rst_term", term, 4'h0);
    check("rst_rel", rel, 4'h0);
    check("rst_term_any", term_any, 0);
    check("rst_term_idx", term_idx, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs are checked before any clock edge.
  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_release();
  endtask

  int hold [CH];

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    rst = 1'b0;
    model_release();
    run(4);

    // Clean press on ch0, held into HELD, then a bouncy release.
    a[0] = 1'b0;
    run(60);
    for (int i = 0; i < 5; i++) begin
      a[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
      run(1);
    end
    a[0] = 1'b1;
    run(25);

    // Two-cycle glitch on ch1.
    a[1] = 1'b0;
    run(2);
    a[1] = 1'b1;
    run(25);

    // Bouncy make on ch2.
    for (int i = 0; i < 5; i++) begin
      a[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
      run(1);
    end
    a[2] = 1'b0;
    run(40);
    a[2] = 1'b1;
    run(25);

    // Simultaneous presses on ch1 and ch3.
    a[1] = 1'b0;
    a[3] = 1'b0;
    run(30);
    a[1] = 1'b1;
    a[3] = 1'b1;
    run(25);

    // Reset while ch0 is in MAKE with count 5, input still held low afterwards.
    a[0] = 1'b0;
    run(7);
    pulse_reset();
    run(40);
    a[0] = 1'b1;
    run(25);

    // Randomised per-channel hold times mixing short glitches and long presses.
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 40);
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          a[c]    = ~a[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end
      end
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else run(1);
    end

    a = '1;
    run(40);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
